// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tow_pkg
// Description : Shared types and constants for the tug-of-war controller:
//               game state encoding, LED bar patterns, rope positions.
// Revision    : 1.0 - initial release
// ============================================================================
package tow_pkg;

  // Game state encoding
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    PLAY  = 2'd1,
    WIN_L = 2'd2,
    WIN_R = 2'd3
  } state_t;

  // LED bar patterns (bit 6 leftmost, bit 0 rightmost)
  localparam logic [6:0] LED_ALL_ON = 7'h7F;
  localparam logic [6:0] LED_OFF    = 7'h00;
  localparam logic [6:0] LED_WIN_L  = 7'b1110000;
  localparam logic [6:0] LED_WIN_R  = 7'b0000111;

  // Rope positions: 0 is the rightmost LED, POS_MAX the leftmost
  localparam logic [2:0] POS_CENTRE = 3'd3;
  localparam logic [2:0] POS_MAX    = 3'd6;

endpackage : tow_pkg
`default_nettype wire

// File: rtl/tow_button.sv
`default_nettype none
// ============================================================================
// Module      : tow_button
// Description : Pushbutton front end: 2-flop synchronizer, optional
//               debounce filter, rising-edge detector. Emits a one-cycle
//               press pulse per accepted rising edge of the button level.
//               Optional debounce enabled by macro TOW_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tow_button #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,      // asynchronous, active-low
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Two-stage synchronizer for the asynchronous button pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef TOW_DEBOUNCE_EN
  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [c_DB_W-1:0] r_db_cnt;
  logic              r_db_level;

  // Accept a new level only after it has differed from the accepted one
  // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_sync2 == r_db_level) begin
      r_db_cnt   <= '0;
    end else if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_level <= r_sync2;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt   <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_db_level;
`else
  assign w_level = r_sync2;

  // Depth is only meaningful with debounce built in; a non-positive value
  // is flagged by this otherwise empty, clearly named scope
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_depth_invalid
  end
`endif

  // Previous-level register for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  // Holding the button yields exactly one pulse
  assign o_press = w_level & ~r_prev;

endmodule : tow_button
`default_nettype wire

// File: rtl/tow.sv
`default_nettype none
// ============================================================================
// Module      : tow
// Description : Tug-of-war game controller for a 7-LED bar. A blank phase
//               follows reset, then a single light moves left on pbl and
//               right on pbr; pushing it off an end wins for that player.
//               Optional button debounce enabled by macro TOW_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tow
  import tow_pkg::*;
#(
  parameter int BLANK_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       pbr,
  input  logic       pbl,
  output logic [6:0] led_out
);

  localparam int c_CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  logic               w_press_l;
  logic               w_press_r;
  logic               w_move_l;
  logic               w_move_r;
  state_t             r_state;
  logic [2:0]         r_pos;
  logic [c_CNT_W-1:0] r_cnt;

  tow_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_l (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (pbl),
    .o_press (w_press_l)
  );

  tow_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_r (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (pbr),
    .o_press (w_press_r)
  );

  // Simultaneous presses cancel each other
  assign w_move_l = w_press_l & ~w_press_r;
  assign w_move_r = w_press_r & ~w_press_l;

  // Game FSM; led_out is decoded from the current state so it trails the
  // position update by one register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BLANK;
      r_pos   <= POS_CENTRE;
      r_cnt   <= '0;
      led_out <= LED_ALL_ON;
    end else begin
      case (r_state)
        BLANK: begin
          led_out <= LED_OFF;
          if (r_cnt == c_CNT_W'(BLANK_CYCLES - 1)) begin
            r_state <= PLAY;
            r_pos   <= POS_CENTRE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        PLAY: begin
          led_out <= 7'd1 << r_pos;
          if (w_move_l) begin
            if (r_pos == POS_MAX) r_state <= WIN_L;
            else                  r_pos   <= r_pos + 3'd1;
          end else if (w_move_r) begin
            if (r_pos == 3'd0)    r_state <= WIN_R;
            else                  r_pos   <= r_pos - 3'd1;
          end
        end
        WIN_L:   led_out <= LED_WIN_L;
        WIN_R:   led_out <= LED_WIN_R;
        default: begin
          r_state <= BLANK;
          led_out <= LED_OFF;
        end
      endcase
    end
  end

endmodule : tow
`default_nettype wire

// File: tb/tb_tow.sv
`default_nettype none
// ============================================================================
// Module      : tb_tow
// Description : Directed self-checking bench for the tug-of-war controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tow;

  localparam int BLANK = 16;

  logic       clk;
  logic       rst;
  logic       pbr;
  logic       pbl;
  logic [6:0] led_out;

  int checks;
  int errors;

  tow #(
    .BLANK_CYCLES    (BLANK),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pbr     (pbr),
    .pbl     (pbl),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset, release on a falling edge, and run through the blank phase
  task automatic start_game();
    pbl = 1'b0;
    pbr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(BLANK + 1);
  endtask

  // One press of either/both buttons, long enough for the effect to settle
  task automatic press(input logic left, input logic right);
    pbl = left;
    pbr = right;
    tick(2);
    pbl = 1'b0;
    pbr = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    logic blank_ok;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (led_out !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", led_out, 7'b1111111);
    end
    @(negedge clk);
    rst = 1'b1;
    blank_ok = 1'b1;
    for (int i = 0; i < BLANK; i++) begin
      tick(1);
      if (led_out !== 7'b0000000) blank_ok = 1'b0;
    end
    checks++;
    if (!blank_ok) begin
      errors++;
      $display("FAIL reset_blank: got %b want %b for %0d cycles", led_out, 7'b0000000, BLANK);
    end
    tick(1);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_centre: got %b want %b", led_out, 7'b0001000);
    end
  endtask

  task automatic test_left_win();
    logic lat_ok;
    start_game();
    // First press also checks the three-edge latency
    pbl = 1'b1;
    lat_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (led_out !== 7'b0001000) lat_ok = 1'b0;
    end
    checks++;
    if (!lat_ok) begin
      errors++;
      $display("FAIL latency_early: got %b want %b", led_out, 7'b0001000);
    end
    tick(1);
    checks++;
    if (led_out !== 7'b0010000) begin
      errors++;
      $display("FAIL latency_move: got %b want %b", led_out, 7'b0010000);
    end
    pbl = 1'b0;
    tick(5);
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b0100000) begin
      errors++;
      $display("FAIL left_pos5: got %b want %b", led_out, 7'b0100000);
    end
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b1000000) begin
      errors++;
      $display("FAIL left_pos6: got %b want %b", led_out, 7'b1000000);
    end
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b1110000) begin
      errors++;
      $display("FAIL left_win: got %b want %b", led_out, 7'b1110000);
    end
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b1110000) begin
      errors++;
      $display("FAIL left_win_hold: got %b want %b", led_out, 7'b1110000);
    end
  endtask

  task automatic test_right_win();
    start_game();
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b0000100) begin
      errors++;
      $display("FAIL right_pos2: got %b want %b", led_out, 7'b0000100);
    end
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b0000010) begin
      errors++;
      $display("FAIL right_pos1: got %b want %b", led_out, 7'b0000010);
    end
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b0000001) begin
      errors++;
      $display("FAIL right_pos0: got %b want %b", led_out, 7'b0000001);
    end
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b0000111) begin
      errors++;
      $display("FAIL right_win: got %b want %b", led_out, 7'b0000111);
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b0000111) begin
      errors++;
      $display("FAIL right_win_hold: got %b want %b", led_out, 7'b0000111);
    end
  endtask

  task automatic test_mixed();
    start_game();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL mixed_mid: got %b want %b", led_out, 7'b0001000);
    end
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b0010000) begin
      errors++;
      $display("FAIL mixed_end: got %b want %b", led_out, 7'b0010000);
    end
  endtask

  task automatic test_simultaneous();
    start_game();
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    checks++;
    if (led_out !== 7'b0000100) begin
      errors++;
      $display("FAIL simultaneous: got %b want %b", led_out, 7'b0000100);
    end
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL after_simultaneous: got %b want %b", led_out, 7'b0001000);
    end
  endtask

  task automatic test_hold();
    start_game();
    pbl = 1'b1;
    tick(50);
    pbl = 1'b0;
    tick(6);
    checks++;
    if (led_out !== 7'b0010000) begin
      errors++;
      $display("FAIL hold_one_move: got %b want %b", led_out, 7'b0010000);
    end
  endtask

  task automatic test_blank_press();
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    pbl = 1'b1;
    tick(2);
    pbl = 1'b0;
    tick(BLANK + 1 - 5);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL blank_press_start: got %b want %b", led_out, 7'b0001000);
    end
    tick(5);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL blank_press_discard: got %b want %b", led_out, 7'b0001000);
    end
  endtask

  task automatic test_midgame_reset();
    logic held_ok;
    start_game();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (led_out !== 7'b0100000) begin
      errors++;
      $display("FAIL midgame_pos: got %b want %b", led_out, 7'b0100000);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (led_out !== 7'b1111111) begin
      errors++;
      $display("FAIL midgame_reset_async: got %b want %b", led_out, 7'b1111111);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (led_out !== 7'b1111111) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL midgame_reset_held: got %b want %b", led_out, 7'b1111111);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (led_out !== 7'b0000000) begin
      errors++;
      $display("FAIL midgame_blank: got %b want %b", led_out, 7'b0000000);
    end
    tick(BLANK);
    checks++;
    if (led_out !== 7'b0001000) begin
      errors++;
      $display("FAIL midgame_centre: got %b want %b", led_out, 7'b0001000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pbl    = 1'b0;
    pbr    = 1'b0;
    test_reset();
    test_left_win();
    test_right_win();
    test_mixed();
    test_simultaneous();
    test_hold();
    test_blank_press();
    test_midgame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tow
`default_nettype wire
